// File: rtl/insn_sched_pkg.sv
// Shared constants and helpers for the instruction dispatcher.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package insn_sched_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_OPC_W  = 3;
    localparam int DEF_DEPTH  = 4;

    // Widest instruction / opcode the helper below can handle.
    localparam int MAX_DATA_W = 64;
    localparam int MAX_OPC_W  = 8;

    // Opcode lives in the top opc_w bits of a data_w-wide instruction.
    function automatic logic [MAX_OPC_W-1:0] extract_opcode(
        input logic [MAX_DATA_W-1:0] instr,
        input int unsigned           data_w,
        input int unsigned           opc_w
    );
        logic [MAX_DATA_W-1:0] shifted;
        logic [MAX_OPC_W-1:0]  mask;
        shifted = instr >> (data_w - opc_w);
        mask    = MAX_OPC_W'((32'd1 << opc_w) - 32'd1);
        return MAX_OPC_W'(shifted) & mask;
    endfunction

endpackage

// File: rtl/insn_fifo.sv
// Per-channel instruction FIFO with occupancy count and synchronous flush.
// Latency: a push is visible at the head (empty deasserts) on the next cycle.
// Backpressure: pushes while full and pops while empty are ignored; full is registered-only.
module insn_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;
    logic              do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // While empty, show the slot just popped so the output holds its last head value.
    assign dout = empty ? mem_q[rd_ptr_q - AW'(1)] : mem_q[rd_ptr_q];

    // Next-state: write at wr_ptr, advance pointers modulo DEPTH, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State registers; storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/insn_dispatcher.sv
// Routes host instructions to per-opcode channel FIFOs; unsupported opcodes are counted and dropped.
// Latency: 1 cycle from accepted instruction to out_valid on an empty channel.
// Backpressure: in_ready drops only when the target FIFO is full (or flush/reset); channels are independent.
module insn_dispatcher
    import insn_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int OPC_W  = DEF_OPC_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int LW    = $clog2(DEPTH) + 1
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_instr,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_instr,
    output logic [NUM_CH*LW-1:0]     ch_level,
    output logic [15:0]              drop_cnt
);

    logic [OPC_W-1:0]  opc;
    logic              supported;
    logic              tgt_full;
    logic              accept;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    assign opc       = OPC_W'(extract_opcode(MAX_DATA_W'(in_instr), DATA_W, OPC_W));
    assign supported = (int'(opc) < NUM_CH);

    // Look up the fullness of the addressed channel; unsupported opcodes never stall.
    always_comb begin
        tgt_full = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (opc == OPC_W'(k)) begin
                tgt_full = full[k];
            end
        end
    end

    // full is a registered FIFO flag, so in_ready has no path from out_ready.
    assign in_ready = rst_n & ~flush & (~supported | ~tgt_full);
    assign accept   = in_valid & in_ready;

    // Decode the accepted instruction into a one-hot channel push.
    always_comb begin
        push = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            push[k] = accept & supported & (opc == OPC_W'(k));
        end
    end

    // Saturating count of accepted-but-unsupported instructions.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && !supported && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign out_valid[g] = ~empty[g];
        assign pop[g]       = ~empty[g] & out_ready[g];

        insn_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (push[g]),
            .din   (in_instr),
            .pop   (pop[g]),
            .dout  (out_instr[g*DATA_W +: DATA_W]),
            .full  (full[g]),
            .empty (empty[g]),
            .level (ch_level[g*LW +: LW])
        );
    end

endmodule

// File: tb/tb_insn_dispatcher.sv
// Directed bench for insn_dispatcher with default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_insn_dispatcher;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_instr;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [127:0] out_instr;
    logic [11:0]  ch_level;
    logic [15:0]  drop_cnt;

    int n_chk;
    int n_fail;

    insn_dispatcher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .ch_level  (ch_level),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [2:0]  opc;
        logic [7:0]  pay;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [11:0] exp_lvl;
        logic [15:0] exp_drop;
        int          chk_ch;
        logic [31:0] exp_head;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [31:0] mk(input logic [2:0] opc, input logic [7:0] pay);
        return {opc, 21'h0, pay};
    endfunction

    function automatic logic [31:0] head(input int ch);
        return out_instr[ch*32 +: 32];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 4'hF;
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_ch_level",  64'(ch_level),  64'h0);
        check("reset_drop_cnt",  64'(drop_cnt),  64'h0);
        check("reset_in_ready",  64'(in_ready),  64'h0);
        check("reset_out_instr", 64'(out_instr == '0), 64'h1);
        tick();
        tick();
        rst_n = 1'b1;

        //           vld opc pay    ordy   rdy ov     lvl {l3,l2,l1,l0}              drop  ch  head
        vecs[0]  = '{1'b1, 3'd0, 8'd1,  4'hF,  1'b1, 4'b0001, {3'd0,3'd0,3'd0,3'd1}, 16'd0, 0,  mk(0, 1)};
        vecs[1]  = '{1'b1, 3'd1, 8'd2,  4'hF,  1'b1, 4'b0010, {3'd0,3'd0,3'd1,3'd0}, 16'd0, 1,  mk(1, 2)};
        vecs[2]  = '{1'b1, 3'd2, 8'd3,  4'hF,  1'b1, 4'b0100, {3'd0,3'd1,3'd0,3'd0}, 16'd0, 2,  mk(2, 3)};
        vecs[3]  = '{1'b1, 3'd3, 8'd4,  4'hF,  1'b1, 4'b1000, {3'd1,3'd0,3'd0,3'd0}, 16'd0, 3,  mk(3, 4)};
        vecs[4]  = '{1'b0, 3'd0, 8'd0,  4'hF,  1'b1, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 16'd0, -1, 32'h0};
        vecs[5]  = '{1'b1, 3'd5, 8'd5,  4'hF,  1'b1, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 16'd1, -1, 32'h0};
        vecs[6]  = '{1'b1, 3'd5, 8'd6,  4'hF,  1'b1, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 16'd2, -1, 32'h0};
        vecs[7]  = '{1'b1, 3'd5, 8'd7,  4'hF,  1'b1, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 16'd3, -1, 32'h0};
        vecs[8]  = '{1'b1, 3'd2, 8'd10, 4'hB,  1'b1, 4'b0100, {3'd0,3'd1,3'd0,3'd0}, 16'd3, 2,  mk(2, 10)};
        vecs[9]  = '{1'b1, 3'd2, 8'd11, 4'hB,  1'b1, 4'b0100, {3'd0,3'd2,3'd0,3'd0}, 16'd3, -1, 32'h0};
        vecs[10] = '{1'b1, 3'd2, 8'd12, 4'hB,  1'b1, 4'b0100, {3'd0,3'd3,3'd0,3'd0}, 16'd3, -1, 32'h0};
        vecs[11] = '{1'b1, 3'd2, 8'd13, 4'hB,  1'b1, 4'b0100, {3'd0,3'd4,3'd0,3'd0}, 16'd3, 2,  mk(2, 10)};
        vecs[12] = '{1'b1, 3'd2, 8'd14, 4'hB,  1'b0, 4'b0100, {3'd0,3'd4,3'd0,3'd0}, 16'd3, 2,  mk(2, 10)};
        vecs[13] = '{1'b1, 3'd0, 8'd20, 4'hB,  1'b1, 4'b0101, {3'd0,3'd4,3'd0,3'd1}, 16'd3, 0,  mk(0, 20)};
        vecs[14] = '{1'b0, 3'd0, 8'd0,  4'hB,  1'b1, 4'b0100, {3'd0,3'd4,3'd0,3'd0}, 16'd3, -1, 32'h0};

        // First edge after reset release accepts immediately; table starts here.
        for (int i = 0; i < 15; i++) begin
            in_valid  = vecs[i].vld;
            in_instr  = mk(vecs[i].opc, vecs[i].pay);
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
            tick();
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            check($sformatf("vec%0d_ch_level", i),  64'(ch_level),  64'(vecs[i].exp_lvl));
            check($sformatf("vec%0d_drop_cnt", i),  64'(drop_cnt),  64'(vecs[i].exp_drop));
            if (vecs[i].chk_ch >= 0)
                check($sformatf("vec%0d_head", i), 64'(head(vecs[i].chk_ch)), 64'(vecs[i].exp_head));
        end

        // Drain channel 2 in order, then confirm the last head value is held.
        in_valid  = 1'b0;
        out_ready = 4'hF;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain2_valid%0d", j), 64'(out_valid[2]), 64'h1);
            check($sformatf("drain2_head%0d", j),  64'(head(2)), 64'(mk(2, 8'(10 + j))));
            tick();
        end
        check("drain2_empty", 64'(out_valid), 64'h0);
        check("drain2_hold",  64'(head(2)), 64'(mk(2, 13)));

        // Full channel 1: simultaneous push+pop refuses the push, then retries.
        out_ready = 4'b1101;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            in_instr = mk(1, 8'(30 + j));
            tick();
        end
        check("full1_level4", 64'(ch_level[5:3]), 64'd4);
        in_instr  = mk(1, 34);
        out_ready = 4'hF;
        #1;
        check("full1_in_ready_low", 64'(in_ready), 64'h0);
        tick();
        check("full1_level_after_pop", 64'(ch_level[5:3]), 64'd3);
        check("full1_head_after_pop",  64'(head(1)), 64'(mk(1, 31)));
        out_ready = 4'b1101;
        #1;
        check("full1_in_ready_retry", 64'(in_ready), 64'h1);
        tick();
        check("full1_level_refill", 64'(ch_level[5:3]), 64'd4);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("full1_order%0d", j), 64'(head(1)), 64'(mk(1, 8'(31 + j))));
            tick();
        end
        check("full1_drained", 64'(out_valid), 64'h0);

        // Drop counter saturation: preload near the top, then drop three more.
        force dut.drop_cnt_d = 16'hFFFE;
        tick();
        release dut.drop_cnt_d;
        check("drop_preload", 64'(drop_cnt), 64'hFFFE);
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_instr = mk(5, 8'(j));
            #1;
            check($sformatf("sat_in_ready%0d", j), 64'(in_ready), 64'h1);
            tick();
            check($sformatf("sat_drop%0d", j),  64'(drop_cnt), 64'hFFFF);
            check($sformatf("sat_valid%0d", j), 64'(out_valid), 64'h0);
        end

        // Flush with two entries in every channel.
        out_ready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 2; j++) begin
                in_valid = 1'b1;
                in_instr = mk(3'(k), 8'(40 + j));
                tick();
            end
        end
        check("preflush_level", 64'(ch_level),  64'({3'd2, 3'd2, 3'd2, 3'd2}));
        check("preflush_valid", 64'(out_valid), 64'hF);
        in_instr = mk(0, 99);
        flush    = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'h0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'h0);
        check("flush_level", 64'(ch_level),  64'h0);
        check("flush_drop",  64'(drop_cnt),  64'hFFFF);

        // Asynchronous reset in the middle of a burst.
        in_valid = 1'b1;
        in_instr = mk(3, 60);
        tick();
        in_instr = mk(3, 61);
        tick();
        in_instr = mk(0, 62);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",     64'(out_valid), 64'h0);
        check("arst_level",     64'(ch_level),  64'h0);
        check("arst_drop",      64'(drop_cnt),  64'h0);
        check("arst_in_ready",  64'(in_ready),  64'h0);
        check("arst_out_instr", 64'(out_instr == '0), 64'h1);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_instr = mk(1, 50);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", 64'(out_valid), 64'b0010);
        check("post_rst_head",  64'(head(1)), 64'(mk(1, 50)));
        check("post_rst_level", 64'(ch_level), 64'({3'd0, 3'd0, 3'd1, 3'd0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
